// File: rtl/spram_arbiter.sv
// spram_arbiter: clears a single-port latency-1 RAM after reset/flush,
// then round-robin arbitrates two client ports onto it.
module spram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE = 1024,
  localparam int AW = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  output logic                  init_done,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [AW-1:0]         addr0,
  input  logic [AW-1:0]         addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_we,
  output logic [AW-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  typedef enum logic {INIT, SERVE} state_t;
  localparam logic [AW:0] LAST = (AW+1)'(SIZE - 1);
  state_t r_state, w_next;
  logic [AW:0] r_cnt, w_cnt;
  logic r_lp;
  logic [1:0] r_rvalid, w_gnt;
  logic [AW-1:0] r_addr;
  logic w_init, w_serve;
  // outputs are forced to their reset values while rst is held
  assign w_init = r_state == INIT && !rst;
  assign w_serve = r_state == SERVE && !rst;
  always_comb begin
    w_next = r_state;
    w_cnt = r_cnt;
    w_gnt = 2'b00;
    if (r_state == INIT) begin
      w_cnt = (flush || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      w_next = (!flush && r_cnt == LAST) ? SERVE : INIT;
    end else if (flush) begin
      w_next = INIT;
      w_cnt = '0;
    end else if (w_serve) begin
      w_gnt[0] = req[0] & (~req[1] | r_lp);
      w_gnt[1] = req[1] & (~req[0] | ~r_lp);
    end
  end
  assign gnt = w_gnt;
  assign init_done = w_serve;
  assign rvalid = r_rvalid;
  assign rdata = ram_dout;
  assign ram_we = w_init | (|(w_gnt & we));
  assign ram_addr = w_init ? r_cnt[AW-1:0] : w_gnt[1] ? addr1 : w_gnt[0] ? addr0 : r_addr;
  assign ram_din = w_gnt[1] ? wdata1 : w_gnt[0] ? wdata0 : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt <= '0;
      r_lp <= 1'b1;
      r_rvalid <= 2'b00;
      r_addr <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_lp <= (|w_gnt) ? w_gnt[1] : r_lp;
      r_rvalid <= w_gnt & ~we;
      r_addr <= ram_addr;
    end
  end
endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: randomized scoreboard bench with a behavioural RAM/arbiter model.
module tb_spram_arbiter;
  localparam int DW = 32, SZ = 16, AW = 4;
  logic clk = 0, rst = 1, flush = 0;
  logic [1:0] req = 0, we = 0;
  logic [AW-1:0] addr0 = 0, addr1 = 0;
  logic [DW-1:0] wdata0 = 0, wdata1 = 0;
  logic init_done, ram_we;
  logic [1:0] gnt, rvalid;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;
  always #5 clk = ~clk;
  spram_arbiter #(.DATA_WIDTH(DW), .SIZE(SZ)) dut (
    .clk(clk), .rst(rst), .flush(flush), .init_done(init_done),
    .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );
  // write-first RAM, pre-filled with garbage so the clear is observable
  logic [DW-1:0] ram [SZ];
  bit seeded = 0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < SZ; i++) ram[i] <= $urandom;
      seeded <= 1;
    end else if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram_we ? ram_din : ram[ram_addr];
  end
  typedef struct {int p; logic [DW-1:0] d; int c;} exp_t;
  exp_t sbq[$];
  int tests = 0, fails = 0, cyc = 0;
  logic [DW-1:0] mem_ref [SZ];
  int init_left = SZ, last_w = 1;
  logic [AW-1:0] last_addr = 0;
  bit prev_rs = 1;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", n, cyc, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].c + 1 == cyc) begin
      chk("rvalid", rvalid, 64'(1 << sbq[0].p));
      chk("rdata", rdata, sbq[0].d);
      void'(sbq.pop_front());
    end else chk("rvalid_idle", rvalid, 0);
  end
  task automatic step(input logic [1:0] rq, input logic [1:0] wv, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic fl, input logic rs, output logic [1:0] g);
    int win, idx;
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    rst = rs; flush = fl; req = rq; we = wv;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    @(negedge clk);
    g = gnt;
    if (rs) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_din", ram_din, 0);
      if (prev_rs) chk("rst_ram_addr", ram_addr, 0);
      init_left = SZ; last_w = 1; last_addr = 0;
    end else if (init_left > 0) begin
      idx = SZ - init_left;
      chk("init_gnt", gnt, 0);
      chk("init_done_low", init_done, 0);
      chk("init_ram_we", ram_we, 1);
      chk("init_ram_addr", ram_addr, idx);
      chk("init_ram_din", ram_din, 0);
      mem_ref[idx] = 0;
      last_addr = AW'(idx);
      init_left = fl ? SZ : init_left - 1;
    end else begin
      chk("init_done_high", init_done, 1);
      win = fl ? -1 : rq == 2'b11 ? 1 - last_w : rq[0] ? 0 : rq[1] ? 1 : -1;
      chk("gnt", gnt, win < 0 ? 0 : 64'(1 << win));
      if (win < 0) begin
        chk("idle_ram_we", ram_we, 0);
        chk("idle_ram_addr", ram_addr, last_addr);
        if (fl) init_left = SZ;
      end else begin
        a = win == 1 ? a1 : a0;
        chk("ram_we", ram_we, wv[win]);
        chk("ram_addr", ram_addr, a);
        if (wv[win]) begin
          chk("ram_din", ram_din, win == 1 ? d1 : d0);
          mem_ref[a] = win == 1 ? d1 : d0;
        end else sbq.push_back('{win, mem_ref[a], cyc});
        last_w = win;
        last_addr = a;
      end
    end
    prev_rs = rs;
  endtask
  logic [1:0] g, pr = 0, pw = 0;
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];
  initial begin
    repeat (2) step(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, g);
    repeat (SZ) step(2'b11, 2'b00, 3, 9, 0, 0, 0, 0, g);
    for (int i = 0; i < SZ; i++) step(2'b01, 2'b00, AW'(i), 0, 0, 0, 0, 0, g);
    step(2'b01, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0, g);
    step(2'b10, 2'b00, 0, 5, 0, 0, 0, 0, g);
    repeat (6) step(2'b11, 2'b00, 1, 2, 0, 0, 0, 0, g);
    repeat (4) step(2'b10, 2'b00, 0, 7, 0, 0, 0, 0, g);
    step(2'b11, 2'b00, 4, 7, 0, 0, 0, 0, g);
    step(2'b01, 2'b00, 5, 0, 0, 0, 0, 0, g);
    step(2'b11, 2'b00, 5, 5, 0, 0, 1, 0, g);
    repeat (SZ) step(2'b11, 2'b00, 5, 5, 0, 0, 0, 0, g);
    step(2'b01, 2'b00, 5, 0, 0, 0, 0, 0, g);
    step(2'b00, 2'b00, 0, 0, 0, 0, 1, 0, g);
    repeat (7) step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, g);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, g);
    repeat (SZ) step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, g);
    repeat (400) begin
      for (int p = 0; p < 2; p++)
        if (!pr[p] && $urandom_range(0, 2) != 0) begin
          pr[p] = 1;
          pw[p] = 1'($urandom_range(0, 1));
          pa[p] = AW'($urandom_range(0, SZ - 1));
          pd[p] = $urandom;
        end
      step(pr, pw, pa[0], pa[1], pd[0], pd[1], $urandom_range(0, 79) == 0, 0, g);
      pr = pr & ~g;
    end
    repeat (3) step(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, g);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
